// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  // Operand and result half-width; the datapath is only built for 8.
  localparam int WIDTH = 8;

  // Operation select encoding on the op input.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the CPU decoder and the multiply/divide unit.
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic             start;
  logic             op;
  logic             sgn;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             cf;
  logic             vf;
  logic             div_zero;

  // Requester side (CPU decoder).
  modport master (
    output start, op, sgn, a_in, b_in,
    input  busy, done, res_lo, res_hi, cf, vf, div_zero
  );

  // Arithmetic unit side.
  modport slave (
    input  start, op, sgn, a_in, b_in,
    output busy, done, res_lo, res_hi, cf, vf, div_zero
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative 8x8 multiply / 8/8 divide unit, signed or unsigned.
// One shift-add or restoring shift-subtract step per clock over a single
// shared adder/subtractor, followed by a sign-correction/flag cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = mul_div_unit_pkg::WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);

  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  state_t               state;
  logic [3:0]           count;
  logic                 op_r;
  logic                 sgn_r;
  logic                 neg_p;      // product or quotient is negative
  logic                 neg_r;      // remainder is negative (dividend sign)
  logic [WIDTH-1:0]     acc;        // MUL: product high half; DIV: partial remainder
  logic [WIDTH-1:0]     sh;         // MUL: multiplier/product low; DIV: dividend/quotient
  logic [WIDTH-1:0]     bm;         // MUL: multiplicand magnitude; DIV: divisor magnitude

  logic                 busy_r;
  logic                 done_r;
  logic [WIDTH-1:0]     res_lo_r;
  logic [WIDTH-1:0]     res_hi_r;
  logic                 cf_r;
  logic                 vf_r;
  logic                 div_zero_r;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 div_by_zero;

  logic [WIDTH:0]       add_x;
  logic [WIDTH:0]       add_y;
  logic                 add_cin;
  logic [WIDTH+1:0]     add_sum;
  logic                 no_borrow;
  logic [WIDTH-1:0]     step_acc;
  logic [WIDTH-1:0]     step_sh;

  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;
  logic [WIDTH-1:0]     fix_lo;
  logic [WIDTH-1:0]     fix_hi;
  logic                 fix_cf;
  logic                 fix_vf;

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.res_lo   = res_lo_r;
  assign bus.res_hi   = res_hi_r;
  assign bus.cf       = cf_r;
  assign bus.vf       = vf_r;
  assign bus.div_zero = div_zero_r;

  // Operand magnitudes and divide-by-zero detection at request time.
  always_comb begin
    a_mag       = (bus.sgn && bus.a_in[WIDTH-1]) ? -bus.a_in : bus.a_in;
    b_mag       = (bus.sgn && bus.b_in[WIDTH-1]) ? -bus.b_in : bus.b_in;
    div_by_zero = (bus.op == OP_DIV) && (bus.b_in == '0);
  end

  // Shared adder/subtractor and the per-iteration register update.
  always_comb begin
    if (op_r == OP_DIV) begin
      add_x   = {acc, sh[WIDTH-1]};
      add_y   = ~{1'b0, bm};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc};
      add_y   = sh[0] ? {1'b0, bm} : '0;
      add_cin = 1'b0;
    end
    add_sum   = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    no_borrow = add_sum[WIDTH+1];
    if (op_r == OP_DIV) begin
      // Restoring step: keep the difference only when it did not go negative.
      step_acc = no_borrow ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
      step_sh  = {sh[WIDTH-2:0], no_borrow};
    end else begin
      step_acc = add_sum[WIDTH:1];
      step_sh  = {add_sum[0], sh[WIDTH-1:1]};
    end
  end

  // Sign correction and flag generation for the FIX cycle.
  always_comb begin
    prod   = {acc, sh};
    prod_s = neg_p ? -prod : prod;
    quo_s  = neg_p ? -sh : sh;
    rem_s  = neg_r ? -acc : acc;
    fix_lo = prod_s[WIDTH-1:0];
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_cf = 1'b0;
    fix_vf = 1'b0;
    if (div_zero_r) begin
      // acc carries the raw dividend when the iteration was skipped.
      fix_lo = '1;
      fix_hi = acc;
    end else if (op_r == OP_DIV) begin
      fix_lo = quo_s;
      fix_hi = rem_s;
      // A positive signed quotient of magnitude 2^(WIDTH-1) only arises
      // from the most-negative dividend over -1.
      fix_vf = sgn_r && !neg_p && sh[WIDTH-1];
    end else begin
      if (sgn_r) begin
        fix_cf = (fix_hi != {WIDTH{fix_lo[WIDTH-1]}});
      end else begin
        fix_cf = (fix_hi != '0);
      end
      fix_vf = fix_cf;
    end
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      op_r       <= OP_MUL;
      sgn_r      <= 1'b0;
      neg_p      <= 1'b0;
      neg_r      <= 1'b0;
      acc        <= '0;
      sh         <= '0;
      bm         <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      res_lo_r   <= '0;
      res_hi_r   <= '0;
      cf_r       <= 1'b0;
      vf_r       <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op_r   <= bus.op;
            sgn_r  <= bus.sgn;
            count  <= '0;
            busy_r <= 1'b1;
            neg_p  <= bus.sgn && (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
            if (div_by_zero) begin
              // Skip the iteration; FIX forms the fixed divide-by-zero result.
              div_zero_r <= 1'b1;
              acc        <= bus.a_in;
              sh         <= '0;
              bm         <= '0;
              neg_r      <= 1'b0;
              state      <= FIX;
            end else begin
              div_zero_r <= 1'b0;
              acc        <= '0;
              state      <= CALC;
              if (bus.op == OP_DIV) begin
                sh    <= a_mag;
                bm    <= b_mag;
                neg_r <= bus.sgn && bus.a_in[WIDTH-1];
              end else begin
                sh    <= b_mag;
                bm    <= a_mag;
                neg_r <= 1'b0;
              end
            end
          end
        end
        CALC: begin
          acc   <= step_acc;
          sh    <= step_sh;
          count <= count + 4'd1;
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          res_lo_r <= fix_lo;
          res_hi_r <= fix_hi;
          cf_r     <= fix_cf;
          vf_r     <= fix_vf;
          done_r   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an integer-arithmetic model.
module tb_mul_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mul_div_unit_if bus ();

  mul_div_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {res_lo, res_hi, cf, vf, div_zero} from plain integer arithmetic.
  function automatic logic [18:0] ref_op(input logic op, input logic sgn,
                                         input logic [7:0] a, input logic [7:0] b);
    int          sa, sb, p, q, r;
    logic [31:0] pv, qv, rv;
    logic        ovf;
    if (!op) begin
      if (sgn) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = sa * sb;
        ovf = (p < -128) || (p > 127);
      end else begin
        p  = int'({24'd0, a}) * int'({24'd0, b});
        ovf = (p > 255);
      end
      pv = p;
      return {pv[7:0], pv[15:8], ovf, ovf, 1'b0};
    end
    if (b == 8'd0) return {8'hFF, a, 1'b0, 1'b0, 1'b1};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) return {8'h80, 8'h00, 1'b0, 1'b1, 1'b0};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = int'({24'd0, a}) / int'({24'd0, b});
      r = int'({24'd0, a}) % int'({24'd0, b});
    end
    qv = q;
    rv = r;
    return {qv[7:0], rv[7:0], 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic int ref_lat(input logic op, input logic [7:0] b);
    return (op && b == 8'd0) ? 2 : 10;
  endfunction

  // Issue one request once idle and wait for done; lat counts the accepting
  // edge as cycle 1, -1 on timeout. Operand inputs are scrambled while busy.
  task automatic exec_op(input logic op, input logic sgn, input logic [7:0] a,
                         input logic [7:0] b, output int lat, output logic [18:0] obs);
    int guard;
    guard = 0;
    while (bus.busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.op = op; bus.sgn = sgn; bus.a_in = a; bus.b_in = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 1'($urandom); bus.sgn = 1'($urandom);
    bus.a_in = 8'($urandom); bus.b_in = 8'($urandom);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c + 1;
        break;
      end
    end
    obs = {bus.res_lo, bus.res_hi, bus.cf, bus.vf, bus.div_zero};
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {bus.busy, bus.done, bus.res_lo, bus.res_hi, bus.cf, bus.vf, bus.div_zero};
    checks++;
    if (obs !== 23'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_directed();
    logic        t_op [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        t_sg [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  t_a  [6] = '{8'hFF, 8'hFD, 8'd200, 8'hF9, 8'h55, 8'h80};
    logic [7:0]  t_b  [6] = '{8'hFF, 8'h05, 8'd7, 8'h02, 8'h00, 8'hFF};
    logic [18:0] t_exp[6] = '{{8'h01, 8'hFE, 3'b110}, {8'hF1, 8'hFF, 3'b000},
                              {8'h1C, 8'h04, 3'b000}, {8'hFD, 8'hFF, 3'b000},
                              {8'hFF, 8'h55, 3'b001}, {8'h80, 8'h00, 3'b010}};
    int          lat;
    logic [18:0] obs;
    for (int i = 0; i < 6; i++) begin
      exec_op(t_op[i], t_sg[i], t_a[i], t_b[i], lat, obs);
      checks++;
      if (obs !== t_exp[i]) begin
        errors++;
        $display("FAIL directed_%0d_result: got %h expected %h", i, obs, t_exp[i]);
      end
      checks++;
      if (lat !== ref_lat(t_op[i], t_b[i])) begin
        errors++;
        $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat,
                 ref_lat(t_op[i], t_b[i]));
      end
    end
  endtask

  task automatic test_random();
    logic        op, sgn;
    logic [7:0]  a, b;
    int          lat;
    logic [18:0] obs, exp;
    for (int i = 0; i < 60; i++) begin
      op  = 1'($urandom);
      sgn = 1'($urandom);
      a   = 8'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      exp = ref_op(op, sgn, a, b);
      exec_op(op, sgn, a, b, lat, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_%0d op=%0b sgn=%0b a=%h b=%h: got %h expected %h",
                 i, op, sgn, a, b, obs, exp);
      end
      checks++;
      if (lat !== ref_lat(op, b)) begin
        errors++;
        $display("FAIL random_%0d_latency: got %0d expected %0d", i, lat, ref_lat(op, b));
      end
    end
  endtask

  task automatic test_hold();
    int          lat;
    logic [18:0] obs, exp;
    exp = ref_op(1'b1, 1'b1, 8'h9C, 8'h07);
    exec_op(1'b1, 1'b1, 8'h9C, 8'h07, lat, obs);
    repeat (4) begin
      bus.a_in = 8'($urandom); bus.b_in = 8'($urandom);
      @(posedge clk); #1;
    end
    obs = {bus.res_lo, bus.res_hi, bus.cf, bus.vf, bus.div_zero};
    checks++;
    if (obs !== exp || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL hold_results: got %h busy=%b done=%b expected %h idle",
               obs, bus.busy, bus.done, exp);
    end
  endtask

  task automatic test_busy_start();
    logic [18:0] obs, exp;
    int          lat;
    exp = ref_op(1'b0, 1'b1, 8'h85, 8'h13);
    bus.op = 1'b0; bus.sgn = 1'b1; bus.a_in = 8'h85; bus.b_in = 8'h13; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c + 1;
        break;
      end
      bus.start = (c == 3 || c == 7);
      bus.op    = 1'b1;
      bus.a_in  = 8'($urandom);
      bus.b_in  = 8'd0;
    end
    obs = {bus.res_lo, bus.res_hi, bus.cf, bus.vf, bus.div_zero};
    checks++;
    if (obs !== exp || lat !== 10) begin
      errors++;
      $display("FAIL busy_start_result: got %h lat=%0d expected %h lat=10", obs, lat, exp);
    end
    // Request presented during the done cycle must not be taken.
    bus.start = 1'b1; bus.op = 1'b0; bus.a_in = 8'h11; bus.b_in = 8'h22;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL start_at_done: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_at_done_late: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [18:0] obs, exp;
    for (int i = 0; i < 3; i++) begin
      exp = ref_op(i[0], 1'b0, 8'hC8 + 8'(i), 8'h03);
      exec_op(i[0], 1'b0, 8'hC8 + 8'(i), 8'h03, lat, obs);
      checks++;
      if (obs !== exp || lat !== 10) begin
        errors++;
        $display("FAIL back_to_back_%0d: got %h lat=%0d expected %h lat=10", i, obs, lat, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [18:0] obs, exp;
    logic [22:0] all;
    logic        saw_done;
    exec_op(1'b0, 1'b0, 8'hFF, 8'hFF, lat, obs);
    @(posedge clk); #1;
    bus.op = 1'b0; bus.sgn = 1'b0; bus.a_in = 8'h37; bus.b_in = 8'h59; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    all = {bus.busy, bus.done, bus.res_lo, bus.res_hi, bus.cf, bus.vf, bus.div_zero};
    checks++;
    if (all !== 23'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected 0", all);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got activity=%b expected 0", saw_done);
    end
    exp = ref_op(1'b0, 1'b0, 8'h37, 8'h59);
    exec_op(1'b0, 1'b0, 8'h37, 8'h59, lat, obs);
    checks++;
    if (obs !== exp || lat !== 10) begin
      errors++;
      $display("FAIL reset_mid_recover: got %h lat=%0d expected %h lat=10", obs, lat, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.sgn = 1'b0;
    bus.a_in = 8'd0; bus.b_in = 8'd0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, 8, operand and result half-width in bits; only 8 is supported.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  1  0 = MUL, 1 = DIV.
REQ-006 sgn  input  1  0 = unsigned, 1 = two's-complement signed.
REQ-007 a_in  input  8  multiplicand or dividend.
REQ-008 b_in  input  8  multiplier or divisor.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse; results are valid in that cycle.
REQ-011 res_lo  output  8  MUL: product[7:0]; DIV: quotient.
REQ-012 res_hi  output  8  MUL: product[15:8]; DIV: remainder.
REQ-013 cf, vf  output  1 each  overflow flags for the CPU flags register.
REQ-014 div_zero  output  1  high if the last DIV had b_in = 0.

Function
REQ-015 States: IDLE, CALC, FIX, DONE; single 4-bit iteration counter.
REQ-016 IDLE + start=1 at edge k: latch op, sgn, a_in and b_in; convert signed operands to magnitudes and record result signs; go to CALC with count = 0.
REQ-017 CALC: one shift-add (MUL) or restoring shift-subtract (DIV) step per edge; after the edge with count = 7, go to FIX.
REQ-018 FIX: apply sign correction and compute flags, taking one edge, then go to DONE.
REQ-019 DONE: done = 1 for exactly one cycle, then IDLE; edge k+9 enters DONE, so done is observed 10 cycles after start is sampled.
REQ-020 res_lo, res_hi, cf, vf and div_zero hold their values from DONE until the next accepted start updates them.
REQ-021 While busy, start is ignored and the operand inputs may change freely.
REQ-022 Unsigned MUL: cf = vf = (res_hi != 0).
REQ-023 Signed MUL: cf = vf = (res_hi != replication of res_lo[7]).
REQ-024 DIV quotient truncates toward zero; remainder takes the sign of the dividend; cf = 0.
REQ-025 Signed DIV -128 / -1: vf = 1, res_lo = 0x80, res_hi = 0x00; vf = 0 for every other DIV.
REQ-026 DIV with b_in = 0: from IDLE go directly to DONE at the next edge (done 2 cycles after start).
REQ-027 In the divide-by-zero case: div_zero = 1, res_lo = 0xFF, res_hi = a_in, cf = vf = 0.
REQ-028 div_zero clears on the next accepted start.
REQ-029 start asserted in the same cycle as done is ignored; it is accepted at the earliest in the following (IDLE) cycle.

Reset
REQ-030 reset asserted forces IDLE immediately, regardless of clk or current state.
REQ-031 reset clears: busy, done, res_lo, res_hi, cf, vf, div_zero, the counter and all operand registers.
REQ-032 reset mid-operation discards the operation with no done pulse; the first edge after release finds the block in IDLE.

Structure
REQ-033 Shared package or header holds: op encodings (OP_MUL, OP_DIV), state encodings and WIDTH.
REQ-034 Single module; one 9-bit adder/subtractor is shared by MUL and DIV; no sub-module.
REQ-035 Instantiated by the cpu decoder for its MUL REG,REG and DIV REG,REG instructions; the decoder holds end_inst low until done.

Verification
REQ-036 Unsigned MUL 0xFF*0xFF -> res_hi = 0xFE, res_lo = 0x01, cf = vf = 1, done exactly 10 cycles after start.
REQ-037 Signed MUL -3*5 (0xFD, 0x05) -> res_hi = 0xFF, res_lo = 0xF1, cf = vf = 0.
REQ-038 Unsigned DIV 200/7 -> res_lo = 0x1C, res_hi = 0x04; signed DIV -7/2 -> res_lo = 0xFD, res_hi = 0xFF.
REQ-039 DIV 0x55/0 -> done 2 cycles after start, div_zero = 1, res_lo = 0xFF, res_hi = 0x55; signed -128/-1 -> vf = 1, res_lo = 0x80, res_hi = 0x00.
REQ-040 start pulsed while busy -> ignored; result matches the first operation.
REQ-041 reset asserted at CALC count = 3 -> immediate IDLE, all outputs 0, no done pulse; the next start completes normally.
